consmax_vec: RTL and testbench
==============================

// Module: consmax_vec
// PURPOSE
//  Multi-lane ConSmax exponent unit with valid/ready flow control.
//  Per lane: FP score -> scaled, saturated signed INT -> two LUT lookups exp(hi), exp(lo) -> FP multiply = exp(x).
//  Sits between the attention score path and the normaliser; LUTs are loaded by the config bus before use.
// PARAMETERS
//  LANES      4   parallel elements per beat
//  EXP_BIT    8   FP exponent width (bf16 default)
//  MAT_BIT    7   FP mantissa width
//  DATA_BIT   EXP_BIT+MAT_BIT+1   FP word width
//  INT_BIT    8   signed integer width after fp2int, must be even
//  LUT_ADDR   INT_BIT/2   address width of each LUT half (depth 2**LUT_ADDR)
//  CDATA_BIT  8   config shift width
// PORTS
//  clk          in   1                clock, single domain
//  rstn         in   1                asynchronous active-low reset
//  cfg_shift    in   CDATA_BIT        fixed-point scale: int = round(x * 2**cfg_shift)
//  lut_wen      in   1                LUT write request
//  lut_waddr    in   LUT_ADDR+1       [MSB]=0 low table, 1 high table; broadcast to all lanes
//  lut_wdata    in   DATA_BIT         FP LUT entry
//  lut_wready   out  1                write accepted this cycle when lut_wen & lut_wready
//  idata        in   LANES*DATA_BIT   FP scores, lane i at [i*DATA_BIT +: DATA_BIT]
//  idata_valid  in   1                input beat valid
//  idata_ready  out  1                input beat accepted when valid & ready
//  odata        out  LANES*DATA_BIT   FP exp results, same lane packing
//  odata_valid  out  1                output beat valid
//  odata_ready  in   1                downstream accepts output
// BEHAVIOUR
//  Reset: odata=0, odata_valid=0, all stage valids=0, lut_wready=1. LUT contents are not reset (undefined until written).
//  Reset asserted mid-operation drops all in-flight beats; no partial output is emitted.
//  Pipeline: S0 input reg + cfg_shift capture -> S1 fp2int reg -> S2 LUT read (sync RAM) -> S3 fmul, output reg.
//  Latency: 4 cycles from accept to odata_valid when there is no backpressure; throughput 1 beat/cycle.
//  advance = ~odata_valid | odata_ready; every stage moves only on advance (single global enable).
//   Held output data and valid stay stable while stalled.
//  idata_ready = advance & ~lut_wen. A pending write blocks new input.
//  lut_wready = pipeline empty (S0..S3 valid all 0). Write occurs at the clock edge where lut_wen & lut_wready.
//   A read issued in a later cycle returns the new value.
//  lut_wen while the pipeline is non-empty: input is held off and the pipeline drains; the write lands once it is empty.
//  cfg_shift is sampled per beat at acceptance; changing it mid-stream affects only newer beats.
//  fp2int, per lane, with E = exp - bias and bias = 2**(EXP_BIT-1)-1:
//   - mag = {1,mant} shifted by (E + cfg_shift - MAT_BIT).
//   - Round half-up on the last dropped bit.
//   - Saturate to +(2**(INT_BIT-1)-1) or -(2**(INT_BIT-1)), then negate if sign.
//   - exp==0 (zero/subnormal) -> 0.
//   - exp all-ones (inf/NaN) -> saturate by sign.
//   - Underflow (all bits shifted out) -> 0.
//  LUT index: hi = int[INT_BIT-1:LUT_ADDR] (two's complement pattern), lo = int[LUT_ADDR-1:0] (unsigned).
//   Software loads high[h] = exp(signed(h)*2**LUT_ADDR / 2**cfg_shift) and low[l] = exp(l / 2**cfg_shift).
//  fmul, per lane:
//   - sign = xor.
//   - mant = {1,ma}*{1,mb}, normalised by 1 on MSB carry, truncated (no rounding).
//   - exp = ea + eb - bias + carry, computed EXP_BIT+2 wide and signed.
//   - Either exponent 0 -> +/-0.
//   - Result exp <= 0 -> +/-0.
//   - Result exp >= all-ones -> +/-inf (exp all-ones, mant 0).
//  Lanes are independent; no cross-lane arithmetic.
// STRUCTURE
//  Package consmax_pkg:
//   - FP field-extract functions and the bias constant.
//   - Saturation limits for INT_BIT.
//   - LUT-select bit index.
//  Sub-module consmax_lane (one per lane, generate loop):
//   - fp2int, two LUT banks with a shared write port, fmul.
//   - Takes the global enable.
//  Top holds the handshake, the stage valid chain, lut_wready and the write broadcast.
// TESTING (bf16, LANES=4, INT_BIT=8, LUT_ADDR=4; tables loaded with exact exp values for cfg_shift=0)
//  1. Load low[1]=0x402E (e), high[0]=0x3F80 (1.0).
//     Input 0x3F80 on all lanes -> odata lanes 0x402E, odata_valid exactly 4 cycles after accept.
//  2. Lane inputs 0x0000, 0x7F80, 0xFF80, 0x4400 (512.0) -> int 0, +127, -128, +127.
//     Check LUT indices (hi,lo) = (0,0), (7,15), (8,0), (7,15) via the expected products.
//  3. Stream 8 beats, hold odata_ready=0 for 5 cycles mid-stream.
//     -> no beat lost or duplicated, odata stable while stalled, order preserved.
//  4. Assert lut_wen while 3 beats are in flight.
//     -> idata_ready=0 and lut_wready=0 until drained, write lands after the last output, next read sees the new value.
//  5. fmul corners:
//     - high entry 0x7F00 x low entry 0x7F00 -> 0x7F80 (inf).
//     - 0x0080 x 0x0080 -> 0x0000 (underflow).
//     - Negative x positive -> sign set.
//  6. Assert rstn low with 2 beats in flight.
//     -> odata=0 and odata_valid=0 immediately; after release no stale beat appears.
//     Change cfg_shift 0->2 between beats -> only later beats are scaled (0x3F80 -> int 4).

Source files
------------

// File: rtl/consmax_pkg.sv
// ConSmax shared helpers: FP field extraction, bias,
// integer saturation limits and LUT table-select bit.
package consmax_pkg;

  function automatic logic fp_sgn(input logic [31:0] w, input int db);
    return w[db-1];
  endfunction

  function automatic logic [31:0] fp_exp(input logic [31:0] w,
                                        input int mb, input int eb);
    return (w >> mb) & ((32'd1 << eb) - 32'd1);
  endfunction

  function automatic logic [31:0] fp_man(input logic [31:0] w, input int mb);
    return w & ((32'd1 << mb) - 32'd1);
  endfunction

  function automatic int fp_bias(input int eb);
    return (1 << (eb - 1)) - 1;
  endfunction

  function automatic int sat_pos(input int ib);
    return (1 << (ib - 1)) - 1;
  endfunction

  function automatic int sat_neg(input int ib);
    return 1 << (ib - 1);
  endfunction

  // waddr bit choosing the high (1) or low (0) table
  function automatic int lut_sel(input int la);
    return la;
  endfunction

endpackage

// File: rtl/consmax_lane.sv
// One ConSmax lane: fp2int, split exp LUT lookup, fmul.
// All data stages share the global enable from the top.
module consmax_lane
  import consmax_pkg::*;
#(
  parameter int EXP_BIT   = 8,
  parameter int MAT_BIT   = 7,
  parameter int DATA_BIT  = EXP_BIT + MAT_BIT + 1,
  parameter int INT_BIT   = 8,
  parameter int LUT_ADDR  = INT_BIT / 2,
  parameter int CDATA_BIT = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en_i,
  input  logic [CDATA_BIT-1:0] shift_i,
  input  logic [DATA_BIT-1:0]  din_i,
  input  logic                 we_i,
  input  logic [LUT_ADDR:0]    waddr_i,
  input  logic [DATA_BIT-1:0]  wdata_i,
  output logic [DATA_BIT-1:0]  dout_o
);
  localparam int MW   = INT_BIT + MAT_BIT + 2;
  localparam int EW   = EXP_BIT + 2;
  localparam int PW   = 2 * MAT_BIT + 2;
  localparam int BIAS = fp_bias(EXP_BIT);
  localparam int SEL  = lut_sel(LUT_ADDR);

  logic [DATA_BIT-1:0] d0_q, hi_q, lo_q, dout_q;
  logic [INT_BIT-1:0]  int_q, int_d;
  logic [DATA_BIT-1:0] hi_mem [2**LUT_ADDR];
  logic [DATA_BIT-1:0] lo_mem [2**LUT_ADDR];

  logic               sg;
  logic [EXP_BIT-1:0] ex;
  logic [MAT_BIT:0]   m;
  logic [MW-1:0]      mag, r, lim;
  int                 sh;

  always_comb begin
    sg  = fp_sgn(32'(d0_q), DATA_BIT);
    ex  = EXP_BIT'(fp_exp(32'(d0_q), MAT_BIT, EXP_BIT));
    m   = {1'b1, MAT_BIT'(fp_man(32'(d0_q), MAT_BIT))};
    sh  = int'(ex) - BIAS + int'(shift_i) - MAT_BIT;
    r   = '0;
    mag = '0;
    if (sh >= INT_BIT) begin
      mag = MW'(1) << INT_BIT;
    end else if (sh >= 0) begin
      mag = MW'(m) << sh;
    end else if (-sh <= MAT_BIT + 1) begin
      // keep the last dropped bit in r[0] for half-up rounding
      r   = MW'(m) >> (-sh - 1);
      mag = (r >> 1) + MW'(r[0]);
    end
    lim = sg ? MW'(sat_neg(INT_BIT)) : MW'(sat_pos(INT_BIT));
    if (&ex) mag = lim;
    if (mag > lim) mag = lim;
    if (ex == '0) mag = '0;
    int_d = sg ? INT_BIT'(MW'(0) - mag) : INT_BIT'(mag);
  end

  logic                so, cy;
  logic [EXP_BIT-1:0]  ea, eb;
  logic [PW-1:0]       p;
  logic [MAT_BIT-1:0]  mo;
  logic [EW-1:0]       es;
  logic [DATA_BIT-1:0] prod;

  always_comb begin
    so = fp_sgn(32'(hi_q), DATA_BIT) ^ fp_sgn(32'(lo_q), DATA_BIT);
    ea = EXP_BIT'(fp_exp(32'(hi_q), MAT_BIT, EXP_BIT));
    eb = EXP_BIT'(fp_exp(32'(lo_q), MAT_BIT, EXP_BIT));
    p  = PW'({1'b1, MAT_BIT'(fp_man(32'(hi_q), MAT_BIT))})
       * PW'({1'b1, MAT_BIT'(fp_man(32'(lo_q), MAT_BIT))});
    cy = p[PW-1];
    mo = cy ? MAT_BIT'(p >> (MAT_BIT + 1)) : MAT_BIT'(p >> MAT_BIT);
    es = EW'(ea) + EW'(eb) - EW'(BIAS) + EW'(cy);
    if (ea == '0 || eb == '0 || es[EW-1] || es == '0) begin
      prod = {so, (DATA_BIT-1)'(0)};
    end else if (es >= EW'((1 << EXP_BIT) - 1)) begin
      prod = {so, {EXP_BIT{1'b1}}, MAT_BIT'(0)};
    end else begin
      prod = {so, es[EXP_BIT-1:0], mo};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d0_q   <= '0;
      int_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dout_q <= '0;
    end else if (en_i) begin
      d0_q   <= din_i;
      int_q  <= int_d;
      hi_q   <= hi_mem[int_q[INT_BIT-1:LUT_ADDR]];
      lo_q   <= lo_mem[int_q[LUT_ADDR-1:0]];
      dout_q <= prod;
    end
  end

  // table storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (we_i && waddr_i[SEL]) hi_mem[waddr_i[LUT_ADDR-1:0]] <= wdata_i;
    if (we_i && !waddr_i[SEL]) lo_mem[waddr_i[LUT_ADDR-1:0]] <= wdata_i;
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/consmax_vec.sv
// Multi-lane ConSmax exponent unit: handshake, stage valid
// chain, LUT write arbitration and per-lane datapaths.
module consmax_vec
  import consmax_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int EXP_BIT   = 8,
  parameter int MAT_BIT   = 7,
  parameter int DATA_BIT  = EXP_BIT + MAT_BIT + 1,
  parameter int INT_BIT   = 8,
  parameter int LUT_ADDR  = INT_BIT / 2,
  parameter int CDATA_BIT = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [CDATA_BIT-1:0]      cfg_shift,
  input  logic                      lut_wen,
  input  logic [LUT_ADDR:0]         lut_waddr,
  input  logic [DATA_BIT-1:0]       lut_wdata,
  output logic                      lut_wready,
  input  logic [LANES*DATA_BIT-1:0] idata,
  input  logic                      idata_valid,
  output logic                      idata_ready,
  output logic [LANES*DATA_BIT-1:0] odata,
  output logic                      odata_valid,
  input  logic                      odata_ready
);
  logic [3:0]           v_q, v_d;
  logic [CDATA_BIT-1:0] shift_q;
  logic                 adv, acc, we;

  assign adv         = ~v_q[3] | odata_ready;
  assign lut_wready  = ~|v_q;
  assign idata_ready = adv & ~lut_wen;
  assign acc         = idata_valid & idata_ready;
  assign we          = lut_wen & lut_wready;
  assign odata_valid = v_q[3];
  assign v_d         = {v_q[2:0], acc};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q     <= '0;
      shift_q <= '0;
    end else if (adv) begin
      v_q <= v_d;
      if (acc) shift_q <= cfg_shift;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    consmax_lane #(
      .EXP_BIT  (EXP_BIT),
      .MAT_BIT  (MAT_BIT),
      .DATA_BIT (DATA_BIT),
      .INT_BIT  (INT_BIT),
      .LUT_ADDR (LUT_ADDR),
      .CDATA_BIT(CDATA_BIT)
    ) u_lane (
      .clk    (clk),
      .rstn   (rstn),
      .en_i   (adv),
      .shift_i(shift_q),
      .din_i  (idata[i*DATA_BIT +: DATA_BIT]),
      .we_i   (we),
      .waddr_i(lut_waddr),
      .wdata_i(lut_wdata),
      .dout_o (odata[i*DATA_BIT +: DATA_BIT])
    );
  end

endmodule

// File: tb/tb_consmax_vec.sv
// Scoreboard bench for consmax_vec (bf16, 4 lanes, INT_BIT=8).
// Reference: integer-scaled fp2int, table lookup, FP product.
module tb_consmax_vec;
  logic        clk = 0;
  logic        rstn = 0;
  logic [7:0]  cfg_shift = 0;
  logic        lut_wen = 0;
  logic [4:0]  lut_waddr = 0;
  logic [15:0] lut_wdata = 0;
  logic        lut_wready;
  logic [63:0] idata = 0;
  logic        idata_valid = 0;
  logic        idata_ready;
  logic [63:0] odata;
  logic        odata_valid;
  logic        odata_ready = 1;

  int checks = 0;
  int errors = 0;
  bit done = 0;
  logic [15:0] lo_m [16];
  logic [15:0] hi_m [16];
  logic [63:0] q [$];

  consmax_vec dut (
    .clk(clk), .rstn(rstn), .cfg_shift(cfg_shift),
    .lut_wen(lut_wen), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .lut_wready(lut_wready), .idata(idata), .idata_valid(idata_valid),
    .idata_ready(idata_ready), .odata(odata), .odata_valid(odata_valid),
    .odata_ready(odata_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  function automatic logic [15:0] to_bf16(input real x);
    logic [63:0] b;
    int e, mt;
    b  = $realtobits(x);
    e  = int'(b[62:52]) - 1023 + 127;
    mt = int'(b[51:45]) + int'(b[44]);
    if (mt == 128) begin mt = 0; e++; end
    if (e <= 0) return {b[63], 15'h0};
    if (e >= 255) return {b[63], 8'hFF, 7'h0};
    return {b[63], 8'(e), 7'(mt)};
  endfunction

  // value = 1.mant * 2**(e-127) * 2**sh, rounded half-up, clamped
  function automatic logic [7:0] m_fp2int(input logic [15:0] x, input int sh);
    int e, s;
    longint m, v;
    e = int'(x[14:7]);
    m = 128 + longint'(x[6:0]);
    if (e == 0) return 8'h00;
    if (e == 255) return x[15] ? 8'h80 : 8'h7F;
    s = e - 127 + sh - 7;
    if (s >= 16) v = 100000;
    else if (s >= 0) v = m * (longint'(1) << s);
    else if (s < -30) v = 0;
    else v = (m + (longint'(1) << (-s - 1))) / (longint'(1) << (-s));
    if (x[15]) begin
      if (v > 128) v = 128;
      return 8'(-v);
    end
    if (v > 127) v = 127;
    return 8'(v);
  endfunction

  function automatic logic [15:0] m_fmul(input logic [15:0] a, input logic [15:0] b);
    logic s;
    int ea, eb, e, p, c, mant;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    if (ea == 0 || eb == 0) return {s, 15'h0};
    p    = (128 + int'(a[6:0])) * (128 + int'(b[6:0]));
    c    = (p >= 32768) ? 1 : 0;
    mant = (p >> (7 + c)) - 128;
    e    = ea + eb - 127 + c;
    if (e <= 0) return {s, 15'h0};
    if (e >= 255) return {s, 8'hFF, 7'h0};
    return {s, 8'(e), 7'(mant)};
  endfunction

  function automatic logic [63:0] model(input logic [63:0] d, input logic [7:0] sh);
    logic [63:0] r;
    logic [7:0]  iv;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      iv = m_fp2int(d[i*16 +: 16], int'(sh));
      r[i*16 +: 16] = m_fmul(hi_m[iv[7:4]], lo_m[iv[3:0]]);
    end
    return r;
  endfunction

  function automatic logic [15:0] rnd_fp();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 16'h0000;
    if (k == 1) return {1'($urandom), 8'hFF, 7'h0};
    return {1'($urandom), 8'($urandom_range(118, 136)), 7'($urandom)};
  endfunction

  always @(negedge clk) begin
    if (rstn && odata_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat got %h want none", odata);
      end else begin
        chk("odata", odata, q[0]);
        if (odata_ready) q.delete(0);
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic [7:0] sh);
    bit ok;
    ok = 0;
    idata = d;
    cfg_shift = sh;
    idata_valid = 1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (idata_ready) begin
        ok = 1;
        q.push_back(model(d, sh));
      end
      @(posedge clk); #1;
    end
    idata_valid = 0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got ready=0 want ready=1");
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d, output int waited);
    bit ok;
    ok = 0;
    waited = 0;
    lut_wen = 1;
    lut_waddr = a;
    lut_wdata = d;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (lut_wready) ok = 1;
      else begin
        waited++;
        chk("ready_blocked_by_wen", 64'(idata_ready), 64'd0);
      end
      @(posedge clk); #1;
    end
    lut_wen = 0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout got wready=0 want wready=1");
    end else if (a[4]) hi_m[a[3:0]] = d;
    else lo_m[a[3:0]] = d;
  endtask

  function automatic logic [63:0] rnd_beat();
    return {rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp()};
  endfunction

  initial begin
    int w, n, hs;
    #2;
    chk("rst_odata", odata, 64'd0);
    chk("rst_ovalid", 64'(odata_valid), 64'd0);
    chk("rst_wready", 64'(lut_wready), 64'd1);
    repeat (3) @(posedge clk);
    #1 rstn = 1;

    for (int l = 0; l < 16; l++) begin
      hs = (l > 7) ? l - 16 : l;
      wr({1'b0, 4'(l)}, to_bf16($exp(real'(l))), w);
      wr({1'b1, 4'(l)}, to_bf16($exp(real'(hs * 16))), w);
    end
    wr(5'h01, 16'h402E, w);
    wr(5'h10, 16'h3F80, w);

    // single beat of 1.0 everywhere, latency in edges incl. accept edge
    send({4{16'h3F80}}, 8'd0);
    n = 1;
    while (!odata_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", 64'(n), 64'd4);
    repeat (3) @(posedge clk); #1;

    send({16'h4400, 16'hFF80, 16'h7F80, 16'h0000}, 8'd0);

    // stream with a 5-cycle downstream stall in the middle
    fork
      for (int b = 0; b < 8; b++) send(rnd_beat(), 8'd0);
      begin
        repeat (6) @(posedge clk);
        #1 odata_ready = 0;
        repeat (5) @(posedge clk);
        #1 odata_ready = 1;
      end
    join

    // write request while 3 beats are in flight
    for (int b = 0; b < 3; b++) send({4{16'h3F80}}, 8'd0);
    wr(5'h01, 16'h4000, w);
    chk("wr_waited", 64'(w > 0), 64'd1);
    chk("wr_after_last_out", 64'(q.size()), 64'd0);
    send({4{16'h3F80}}, 8'd0);

    // fmul corners: overflow, underflow, negative sign
    wr(5'h10, 16'h7F00, w);
    wr(5'h02, 16'h7F00, w);
    wr(5'h11, 16'h0080, w);
    wr(5'h00, 16'h0080, w);
    wr(5'h1F, 16'hBF80, w);
    send({16'h3F80, 16'hBF80, 16'h4180, 16'h4000}, 8'd0);

    // random traffic with random backpressure and scale
    done = 0;
    fork
      begin
        for (int b = 0; b < 40; b++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(rnd_beat(), 8'($urandom_range(0, 3)));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          odata_ready = ($urandom_range(0, 3) != 0);
        end
        odata_ready = 1;
      end
    join

    n = 0;
    while (q.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain", 64'(q.size()), 64'd0);

    // reset with 2 beats in flight drops them
    send(rnd_beat(), 8'd0);
    send(rnd_beat(), 8'd0);
    rstn = 0;
    q.delete();
    #1;
    chk("midrst_odata", odata, 64'd0);
    chk("midrst_ovalid", 64'(odata_valid), 64'd0);
    @(posedge clk); #1 rstn = 1;
    repeat (8) @(posedge clk); #1;
    chk("post_rst_wready", 64'(lut_wready), 64'd1);

    // cfg_shift change between beats: 1.0 -> int 1, then int 4
    send({4{16'h3F80}}, 8'd0);
    send({4{16'h3F80}}, 8'd2);
    send({4{16'h3F00}}, 8'd0);
    n = 0;
    while (q.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("final_drain", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
